// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if: bundles the serial data, configuration, counter-control
// and status signals of the programmable sequence detector.
//   master modport : stimulus side, drives data/config/cnt_clr, reads status
//   slave  modport : detector side, reads data/config/cnt_clr, drives status
// The clock and reset stay plain ports on the detector.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;
    logic               cfg_err;
    logic               armed;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  out, match_cnt, cnt_sat, cfg_err, armed
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output out, match_cnt, cnt_sat, cfg_err, armed
    );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-sequence detector (Moore).
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous reset, active-low
//   bus  : seq_detect_prog_if.slave
//          in_valid/in_bit      serial data with bit-valid strobe
//          cfg_load/pattern/len/overlap  runtime configuration
//          cnt_clr              synchronous clear of match_cnt/cnt_sat
//          out                  registered one-cycle match pulse
//          match_cnt/cnt_sat    saturating match counter and sticky flag
//          cfg_err              one-cycle pulse after a rejected cfg_load
//          armed                a valid configuration is loaded
// The first received bit of a pattern is cfg_pattern[cfg_len-1].
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    seq_detect_prog_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               out_q;
    logic               armed_q;
    logic               cfg_err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;

    logic               cfg_ok;
    logic               shift;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    // Next history/fill and the match decision for the bit presented this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
        cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
        shift  = (state_q != IDLE) && bus.in_valid && !bus.cfg_load;
        hist_d = {hist_q[MAX_LEN-2:0], bus.in_bit};
        // fill saturates at len: the window is full once len bits have arrived.
        fill_d = (fill_q == len_q) ? len_q : fill_q + 1'b1;
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        hit = shift && (fill_d == len_q) && (((hist_d ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: configuration and history are reset too, so a reset always forces a reload before any match.
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
            armed_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
            cfg_err_q <= 1'b0;
            if (bus.cfg_load) begin
                // A load wins over in_valid; a rejected load leaves everything else as it was.
                if (cfg_ok) begin
                    pat_q   <= bus.cfg_pattern;
                    len_q   <= bus.cfg_len;
                    ovl_q   <= bus.cfg_overlap;
                    hist_q  <= '0;
                    fill_q  <= '0;
                    state_q <= ARMED;
                    out_q   <= 1'b0;
                    armed_q <= 1'b1;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end else if (state_q != IDLE) begin
                if (shift) begin
                    hist_q <= hist_d;
                    // Non-overlap: a match consumes the window, the next one needs len fresh bits.
                    fill_q <= (hit && !ovl_q) ? '0 : fill_d;
                end
                state_q <= hit ? MATCH : ARMED;
                out_q   <= hit;
            end

            if (bus.cnt_clr) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (hit) begin
                if (&cnt_q) begin
                    sat_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.armed     = armed_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: self-checking bench for seq_detect_prog.
// Main instance (MAX_LEN=8, CNT_W=8) is tracked by a queue-based reference
// model; a second instance with CNT_W=3 exercises counter saturation.
module tb_seq_detect_prog;
    localparam int ML = 8;
    localparam int LW = $clog2(ML) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(ML), .CNT_W(8)) bus ();
    seq_detect_prog_if #(.MAX_LEN(ML), .CNT_W(3)) bus_s ();

    seq_detect_prog #(.MAX_LEN(ML), .CNT_W(8)) dut   (.clk(clk), .rst(rst), .bus(bus));
    seq_detect_prog #(.MAX_LEN(ML), .CNT_W(3)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the bits received since arming (or since the last
    // non-overlapping match), trimmed to the pattern length.
    bit        m_armed, m_out, m_err;
    int        m_len, m_cnt;
    bit        m_ovl;
    bit [7:0]  m_pat;
    bit        win[$];

    task automatic model_reset();
        m_armed = 0; m_out = 0; m_err = 0; m_len = 0; m_cnt = 0; m_ovl = 0; m_pat = '0;
        win.delete();
    endtask

    task automatic model_step(input bit v, input bit b, input bit ld, input bit [7:0] pat,
                              input int len, input bit ovl, input bit clr);
        bit hit = 0;
        bit ok  = (len >= 1) && (len <= ML);
        if (ld) begin
            if (ok) begin
                m_armed = 1; m_pat = pat; m_len = len; m_ovl = ovl; m_out = 0;
                win.delete();
            end
        end else if (m_armed) begin
            if (v) begin
                win.push_back(b);
                if (win.size() > m_len) void'(win.pop_front());
                if (win.size() == m_len) begin
                    hit = 1;
                    for (int k = 0; k < m_len; k++)
                        if (win[k] != m_pat[m_len-1-k]) hit = 0;
                end
                if (hit && !m_ovl) win.delete();
            end
            m_out = hit;
        end
        m_err = ld && !ok;
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < 255) m_cnt++;
    endtask

    // One clock on the main instance; leaves time at posedge+1 for sampling.
    task automatic cycle(input bit v, input bit b, input bit ld, input bit [7:0] pat,
                         input int len, input bit ovl, input bit clr);
        bus.in_valid = v; bus.in_bit = b; bus.cfg_load = ld; bus.cfg_pattern = pat;
        bus.cfg_len = LW'(len); bus.cfg_overlap = ovl; bus.cnt_clr = clr;
        @(posedge clk);
        model_step(v, b, ld, pat, len, ovl, clr);
        #1;
    endtask

    task automatic cycle_s(input bit v, input bit b, input bit ld, input bit clr);
        bus_s.in_valid = v; bus_s.in_bit = b; bus_s.cfg_load = ld; bus_s.cfg_pattern = 8'h01;
        bus_s.cfg_len = LW'(1); bus_s.cfg_overlap = 1'b1; bus_s.cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #3;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #12;
        n_vec++; if (bus.out !== 1'b0) begin n_bad++; $display("FAIL reset_out got=%b exp=0", bus.out); end
        n_vec++; if (bus.match_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.match_cnt); end
        n_vec++; if (bus.cnt_sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got=%b exp=0", bus.cnt_sat); end
        n_vec++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.cfg_err); end
        n_vec++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL reset_armed got=%b exp=0", bus.armed); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_1011(input bit ovl, input bit exp_out [7], input int exp_cnt, input string nm);
        bit stream [7] = '{1, 0, 1, 1, 0, 1, 1};
        cycle(0, 0, 1, 8'b0000_1011, 4, ovl, 1);
        n_vec++; if (bus.armed !== 1'b1) begin n_bad++; $display("FAIL %s_armed got=%b exp=1", nm, bus.armed); end
        for (int i = 0; i < 7; i++) begin
            cycle(1, stream[i], 0, 8'h00, 0, 0, 0);
            n_vec++;
            if (bus.out !== exp_out[i]) begin
                n_bad++; $display("FAIL %s_out bit%0d got=%b exp=%b", nm, i + 1, bus.out, exp_out[i]);
            end
        end
        n_vec++; if (bus.match_cnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL %s_cnt got=%0d exp=%0d", nm, bus.match_cnt, exp_cnt); end
    endtask

    task automatic test_overlap();
        bit e [7] = '{0, 0, 0, 1, 0, 0, 1};
        run_1011(1'b1, e, 2, "ovl");
    endtask

    task automatic test_non_overlap();
        bit e [7] = '{0, 0, 0, 1, 0, 0, 0};
        run_1011(1'b0, e, 1, "novl");
    endtask

    task automatic test_len1_gaps();
        bit v [7] = '{1, 0, 1, 0, 1, 0, 1};
        bit b [7] = '{1, 1, 1, 0, 0, 1, 1};
        bit e [7] = '{1, 0, 1, 0, 0, 0, 1};
        cycle(0, 0, 1, 8'h01, 1, 1, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(v[i], b[i], 0, 8'h00, 0, 0, 0);
            n_vec++;
            if (bus.out !== e[i]) begin n_bad++; $display("FAIL len1_out step%0d got=%b exp=%b", i, bus.out, e[i]); end
        end
        n_vec++; if (bus.match_cnt !== 8'd3) begin n_bad++; $display("FAIL len1_cnt got=%0d exp=3", bus.match_cnt); end
    endtask

    task automatic test_cfg_err();
        do_reset();
        cycle(0, 0, 1, 8'hFF, 0, 1, 0);
        n_vec++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_len0 got=%b exp=1", bus.cfg_err); end
        n_vec++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL err_len0_armed got=%b exp=0", bus.armed); end
        cycle(0, 0, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_end got=%b exp=0", bus.cfg_err); end
        cycle(0, 0, 1, 8'hFF, ML + 1, 1, 0);
        n_vec++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_len9 got=%b exp=1", bus.cfg_err); end
        n_vec++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL err_len9_armed got=%b exp=0", bus.armed); end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 8'h00, 0, 0, 0);
            n_vec++; if (bus.out !== 1'b0) begin n_bad++; $display("FAIL err_idle_out step%0d got=%b exp=0", i, bus.out); end
        end
        n_vec++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_after got=%b exp=0", bus.cfg_err); end
        cycle(0, 0, 1, 8'h01, 1, 1, 0);
        n_vec++; if (bus.armed !== 1'b1) begin n_bad++; $display("FAIL err_reload_armed got=%b exp=1", bus.armed); end
        n_vec++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_reload_err got=%b exp=0", bus.cfg_err); end
    endtask

    task automatic test_saturation();
        cycle_s(0, 0, 1, 1);
        for (int i = 0; i < 9; i++) begin
            cycle_s(1, 1, 0, 0);
            if (i == 6) begin
                n_vec++; if (bus_s.match_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_cnt7 got=%0d exp=7", bus_s.match_cnt); end
            end
        end
        n_vec++; if (bus_s.match_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_hold got=%0d exp=7", bus_s.match_cnt); end
        n_vec++; if (bus_s.cnt_sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag got=%b exp=1", bus_s.cnt_sat); end
        cycle_s(1, 1, 0, 1);
        n_vec++; if (bus_s.out !== 1'b1) begin n_bad++; $display("FAIL sat_clr_out got=%b exp=1", bus_s.out); end
        n_vec++; if (bus_s.match_cnt !== 3'd0) begin n_bad++; $display("FAIL sat_clr_cnt got=%0d exp=0", bus_s.match_cnt); end
        n_vec++; if (bus_s.cnt_sat !== 1'b0) begin n_bad++; $display("FAIL sat_clr_flag got=%b exp=0", bus_s.cnt_sat); end
        cycle_s(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit s [4] = '{1, 0, 1, 1};
        cycle(0, 0, 1, 8'b0000_1011, 4, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, s[i], 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, s[i], 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.match_cnt !== 8'd1) begin n_bad++; $display("FAIL mid_pre_cnt got=%0d exp=1", bus.match_cnt); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL mid_armed got=%b exp=0", bus.armed); end
        n_vec++; if (bus.match_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_cnt got=%0d exp=0", bus.match_cnt); end
        n_vec++; if (bus.out !== 1'b0) begin n_bad++; $display("FAIL mid_out got=%b exp=0", bus.out); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            cycle(1, s[i], 0, 8'h00, 0, 0, 0);
            n_vec++; if (bus.out !== 1'b0) begin n_bad++; $display("FAIL mid_post_out step%0d got=%b exp=0", i, bus.out); end
        end
        n_vec++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL mid_post_armed got=%b exp=0", bus.armed); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit        ld  = ($urandom_range(0, 99) < 4);
            bit        clr = ($urandom_range(0, 99) < 2);
            bit        v   = ($urandom_range(0, 99) < 75);
            bit        b   = 1'($urandom);
            bit [7:0]  pat = 8'($urandom);
            int        len = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 4) : $urandom_range(0, 15);
            bit        ovl = 1'($urandom);
            cycle(v, b, ld, pat, len, ovl, clr);
            n_vec++; if (bus.out !== m_out) begin n_bad++; $display("FAIL rnd_out n=%0d got=%b exp=%b", n, bus.out, m_out); end
            n_vec++; if (bus.match_cnt !== 8'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, bus.match_cnt, m_cnt); end
            n_vec++; if (bus.armed !== m_armed) begin n_bad++; $display("FAIL rnd_armed n=%0d got=%b exp=%b", n, bus.armed, m_armed); end
            n_vec++; if (bus.cfg_err !== m_err) begin n_bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, bus.cfg_err, m_err); end
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.in_bit = 0; bus.cfg_load = 0; bus.cfg_pattern = '0;
        bus.cfg_len = '0; bus.cfg_overlap = 0; bus.cnt_clr = 0;
        bus_s.in_valid = 0; bus_s.in_bit = 0; bus_s.cfg_load = 0; bus_s.cfg_pattern = '0;
        bus_s.cfg_len = '0; bus_s.cfg_overlap = 0; bus_s.cnt_clr = 0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_len1_gaps();
        test_cfg_err();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Programmable serial bit-sequence detector; the parametrised successor of the team's fixed-pattern Moore detector.
- Pattern value, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded at runtime.
- Registered Moore match output, plus a saturating match counter for status readback.
- Sits on a serial data line behind a bit-valid strobe.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- LEN_W, $clog2(MAX_LEN)+1: width of cfg_len (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  load configuration this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] is the last.
- cfg_len  in  LEN_W  pattern length; valid range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = window restarts after each match.
- cnt_clr  in  1  synchronous clear of match_cnt and cnt_sat.
- out  out  1  match flag (Moore, registered).
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  sticky flag: counter has saturated.
- cfg_err  out  1  one-cycle pulse: rejected cfg_load.
- armed  out  1  a valid configuration is loaded.

Behaviour:
- Reset (rst=0, async): state IDLE; out=0, match_cnt=0, cnt_sat=0, cfg_err=0, armed=0; history, fill count and pattern registers cleared.
- States:
  - IDLE: unconfigured.
  - ARMED: configured, no match this cycle.
  - MATCH: configured, match completed. out=1 iff state==MATCH; armed=1 in ARMED and MATCH.
- cfg_load, accepted case: if 1≤cfg_len≤MAX_LEN (any state), latch pattern, len and overlap; clear history and fill to 0; next state ARMED.
- cfg_load, rejected case: cfg_len=0 or >MAX_LEN sets cfg_err=1 for the next cycle only and leaves state and config unchanged.
- cfg_load has priority over in_valid in the same cycle; that in_bit is discarded.
- IDLE: in_valid is ignored.
- ARMED or MATCH with in_valid=1 (and no cfg_load):
  - hist <= {hist[MAX_LEN-2:0], in_bit}; fill <= min(fill+1, len).
  - Match when updated fill==len and updated hist[len-1:0]==pattern[len-1:0].
  - Match: next state MATCH; otherwise ARMED.
- ARMED or MATCH with in_valid=0: history and fill hold; next state ARMED. out is therefore a one-cycle pulse per match.
- Latency: out rises on the clock edge that samples the completing bit; it is visible the cycle after that bit is presented.
- Overlap mode: after a match, fill stays at len, so back-to-back matches are possible.
- Non-overlap mode: on a match, fill is cleared to 0; the next match needs len fresh bits.
- match_cnt: +1 per match.
  - At all-ones it holds and sets cnt_sat.
  - cnt_clr clears both match_cnt and cnt_sat; clr wins over a simultaneous match (result 0, sat 0).
  - cfg_load does not touch the counter.
- Reset mid-stream: immediate return to the reset values above; any configuration must be reloaded.

Test Plan:
- Reset, then load pattern=1011, len=4, overlap=1; feed 1,0,1,1,0,1,1 on consecutive valid cycles -> out pulses after bits 4 and 7, match_cnt=2.
- Same stream with overlap=0 -> single pulse after bit 4, match_cnt=1.
- len=1, pattern=1, stream 1,1,0,1 with in_valid gaps inserted -> out high the cycle after each 1 (3 pulses), low during gaps, match_cnt=3.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses one cycle each, armed stays 0, stream 1111 gives no out; a valid load afterwards gives armed=1.
- CNT_W=3, pattern 1 len=1, 9 ones -> match_cnt=7, cnt_sat=1; cnt_clr on the cycle of a match -> match_cnt=0, cnt_sat=0.
- rst pulled low asynchronously mid-pattern (after 101) -> outputs zero immediately; after release armed=0, and further bits produce no match until reload.
